banco_write_arbiter: RTL and testbench
======================================

# banco_write_arbiter

Write-port controller for the 8×4-bit register bank. It shares the bank's single write port between two requesters using a req/gnt handshake with round-robin priority. It also runs a clear sequencer that zeroes all eight registers on command. It sits between the input sources (switch logic, auto-update logic) and the bank's `addrW`/`datW`/`RegWrite` inputs, replacing direct switch wiring.

## Interface
- `AW`, 3, register address width (bank depth 2^AW = 8)
- `DW`, 4, register data width

- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`  in  1  requester 0 write request; held until `gnt0`
- `addr0`  in  AW  requester 0 target address; stable while `req0`=1
- `data0`  in  DW  requester 0 write data; stable while `req0`=1
- `gnt0`  out  1  one-cycle grant to requester 0
- `req1`, `addr1`, `data1`, `gnt1`: same as requester 0
- `clr`  in  1  clear command (level sampled; one-cycle pulse expected)
- `busy`  out  1  clear sequence in progress
- `RegWrite`  out  1  bank write enable
- `addrW`  out  AW  bank write address
- `datW`  out  DW  bank write data

## Operation
- All outputs are registered. Reset values: `gnt0`=`gnt1`=0, `RegWrite`=0, `addrW`=0, `datW`=0, `busy`=0, state IDLE, round-robin pointer `last`=1 (requester 0 wins the first tie).
- States: IDLE and CLEAR. A 3-bit clear counter `cc` is used in CLEAR.
- IDLE, priority evaluated at each edge:
  1. `clr`=1: go to CLEAR, `cc`=0, and drive the first clear write (`addrW`=0, `datW`=0, `RegWrite`=1, `busy`=1). Pending requests are not granted this edge.
  2. Otherwise, compute effective requests: `req_i` is masked to 0 in any cycle where `gnt_i`=1, because that transaction is consumed.
  3. Exactly one effective request: grant it.
  4. Both effective: grant the requester ≠ `last`.
  5. Granting requester i sets `gnt_i`=1, `RegWrite`=1, `addrW`=`addr_i`, `datW`=`data_i` for the next cycle, and sets `last`=i.
  6. No effective request: `gnt*`=0, `RegWrite`=0, `addrW`/`datW` hold their previous values.
- CLEAR:
  - Each cycle drives `RegWrite`=1, `datW`=0, `addrW`=`cc`, with `cc` incrementing 0..7.
  - At the edge ending the `cc`=7 cycle: `busy`→0, state→IDLE. Arbitration per the IDLE rules (step 1 excluded) is evaluated at this same edge, so a pending request is granted in the very next cycle.
  - `clr` during CLEAR is ignored; it does not restart or extend the sequence.
  - Requests during CLEAR stay pending. No grant is issued and `last` is unchanged.
- At most one of `gnt0`, `gnt1` is high in any cycle. `gnt_i`=1 implies `RegWrite`=1 and `busy`=0.
- `rst` asserted in any state, including mid-CLEAR, returns all outputs to reset values at that edge. The partial clear is abandoned and is not resumed.

## Timing
- Grant latency: `req_i` sampled high at edge E with no competition produces `gnt_i`/`RegWrite` high in the cycle after E. The bank writes at edge E+1.
- Requester handshake:
  - The requester samples `gnt_i` at edge E+1.
  - It must then drop `req_i` or present a new address/data; holding `req_i` high requests another write.
- Throughput:
  - One requester alone: one write every 2 cycles (grant-cycle masking).
  - Both requesters continuously: alternating grants every cycle (0,1,0,1…), one write per cycle.
- Clear: `clr` sampled at edge E gives `busy` high for exactly 8 cycles (E+1..E+8) with `addrW`=0..7. The earliest next grant is the cycle after E+8.
- Simultaneous `clr` and request(s) in IDLE: clear wins and requests wait.

## Test plan
- Reset, then single write: `req0`=1, `addr0`=3, `data0`=9 for one cycle → the next cycle has `gnt0`=1, `RegWrite`=1, `addrW`=3, `datW`=9. Bank read of address 3 returns 9; no second grant while `req0` is low.
- Contention: `req0` and `req1` held high from reset for 6 cycles → grants 0,1,0,1,0,1 on consecutive cycles; `gnt0` and `gnt1` never high together.
- Held single request: `req1` held 6 cycles, `addr1`=5 → `gnt1` on alternate cycles (3 grants); `last`=1, so a following tie grants requester 0.
- Clear: preload addresses 0..7 with 0xF, pulse `clr` → `busy` high for 8 cycles and `addrW` walks 0..7 with `datW`=0. Afterwards all reads return 0. A second `clr` pulse at clear cycle 4 does not extend `busy` past 8 cycles.
- Clear with pending request: `req0`=1, `addr0`=2, `data0`=6 asserted together with `clr` and held → no `gnt0` during `busy`. `gnt0` appears in the cycle right after the `addrW`=7 cycle, and address 2 then reads 6.
- Reset mid-clear: assert `rst` at clear cycle 3 → next cycle `busy`=0, `RegWrite`=0, `addrW`=0. Addresses 0..2 are cleared; addresses 3..7 keep their prior values.

Source files
------------

// File: rtl/banco_write_arbiter.sv
// banco_write_arbiter: shares the register bank's single write port between
// two req/gnt requesters (round-robin) and sequences a full-bank clear.
module banco_write_arbiter #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    input  logic          clr,
    output logic          busy,
    output logic          RegWrite,
    output logic [AW-1:0] addrW,
    output logic [DW-1:0] datW
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cc_q, cc_d;
    logic          last_q, last_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] addrw_q, addrw_d;
    logic [DW-1:0] datw_q, datw_d;
    logic          busy_q, busy_d;

    logic          eff0, eff1;
    logic          arb;
    logic          win0, win1;

    // Next-state, arbitration and clear sequencing
    always_comb begin
        state_d    = state_q;
        cc_d       = cc_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        regwrite_d = 1'b0;
        addrw_d    = addrw_q;
        datw_d     = datw_q;
        busy_d     = 1'b0;
        arb        = 1'b0;

        // A request granted this cycle is being consumed; it cannot win again.
        eff0 = req0 & ~gnt0_q;
        eff1 = req1 & ~gnt1_q;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d    = CLEAR;
                    cc_d       = '0;
                    addrw_d    = '0;
                    datw_d     = '0;
                    regwrite_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    arb = 1'b1;
                end
            end
            CLEAR: begin
                // Last clear write ends here; arbitration runs on the same
                // edge so a waiting requester is granted without a bubble.
                if (cc_q == '1) begin
                    state_d = IDLE;
                    arb     = 1'b1;
                end else begin
                    cc_d       = cc_q + 1'b1;
                    addrw_d    = cc_q + 1'b1;
                    datw_d     = '0;
                    regwrite_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // last_q=1 means requester 1 won most recently, so 0 wins a tie.
        win0 = arb & eff0 & (~eff1 | last_q);
        win1 = arb & eff1 & (~eff0 | ~last_q);

        if (win0) begin
            gnt0_d     = 1'b1;
            regwrite_d = 1'b1;
            addrw_d    = addr0;
            datw_d     = data0;
            last_d     = 1'b0;
        end else if (win1) begin
            gnt1_d     = 1'b1;
            regwrite_d = 1'b1;
            addrw_d    = addr1;
            datw_d     = data1;
            last_d     = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cc_q       <= '0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            regwrite_q <= 1'b0;
            addrw_q    <= '0;
            datw_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cc_q       <= cc_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            regwrite_q <= regwrite_d;
            addrw_q    <= addrw_d;
            datw_q     <= datw_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign RegWrite = regwrite_q;
    assign addrW    = addrw_q;
    assign datW     = datw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_banco_write_arbiter.sv
// Scoreboard bench for banco_write_arbiter: a queue-based reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_banco_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, clr;
    logic [2:0] addr0, addr1;
    logic [3:0] data0, data1;
    logic       gnt0, gnt1, busy, RegWrite;
    logic [2:0] addrW;
    logic [3:0] datW;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       rw;
        logic       bz;
        logic [2:0] a;
        logic [3:0] d;
    } obs_t;

    obs_t sb[$];

    banco_write_arbiter #(.AW(3), .DW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .clr(clr), .busy(busy), .RegWrite(RegWrite), .addrW(addrW), .datW(datW)
    );

    always #5 clk = ~clk;

    // Reference model state: what the DUT should be showing this cycle
    logic       m_g0, m_g1, m_rw, m_bz, m_last;
    logic [2:0] m_a;
    logic [3:0] m_d;
    int         clr_todo[$];  // clear addresses still to be written
    logic [3:0] mbank[8];
    logic [3:0] dbank[8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            mbank[i] = '0;
            dbank[i] = '0;
        end
        m_g0 = 0; m_g1 = 0; m_rw = 0; m_bz = 0; m_last = 1; m_a = 0; m_d = 0;
    end

    // Bank written from the DUT's own write port
    always @(posedge clk) begin
        if (RegWrite === 1'b1) dbank[addrW] <= datW;
    end

    // Reference model: compute next-cycle outputs from the rules, push them
    always @(posedge clk) begin
        bit e0, e1;
        int pick;
        if (m_rw) mbank[m_a] = m_d;
        e0 = req0 && !m_g0;
        e1 = req1 && !m_g1;
        if (rst) begin
            m_g0 = 0; m_g1 = 0; m_rw = 0; m_bz = 0; m_last = 1; m_a = 0; m_d = 0;
            clr_todo.delete();
        end else begin
            m_g0 = 0; m_g1 = 0; m_rw = 0;
            if (!m_bz && clr) begin
                for (int i = 0; i < 8; i++) clr_todo.push_back(i);
            end
            if (clr_todo.size() > 0) begin
                m_a  = 3'(clr_todo.pop_front());
                m_d  = 0;
                m_rw = 1;
                m_bz = 1;
            end else begin
                m_bz = 0;
                pick = -1;
                if (e0 && e1) pick = m_last ? 0 : 1;
                else if (e0) pick = 0;
                else if (e1) pick = 1;
                if (pick == 0) begin
                    m_g0 = 1; m_rw = 1; m_a = addr0; m_d = data0; m_last = 0;
                end else if (pick == 1) begin
                    m_g1 = 1; m_rw = 1; m_a = addr1; m_d = data1; m_last = 1;
                end
            end
        end
        sb.push_back('{m_g0, m_g1, m_rw, m_bz, m_a, m_d});
    end

    // Monitor: one comparison per cycle, plus structural invariants
    always @(negedge clk) begin
        obs_t e, a;
        a = '{gnt0, gnt1, RegWrite, busy, addrW, datW};
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got g0=%b g1=%b rw=%b busy=%b a=%0d d=%0h want g0=%b g1=%b rw=%b busy=%b a=%0d d=%0h",
                         $time, a.g0, a.g1, a.rw, a.bz, a.a, a.d, e.g0, e.g1, e.rw, e.bz, e.a, e.d);
            end
        end
        n_tests++;
        if ((gnt0 && gnt1) || ((gnt0 || gnt1) && (!RegWrite || busy))) begin
            n_fail++;
            $display("FAIL grant_invariant t=%0t got g0=%b g1=%b rw=%b busy=%b want exclusive grant with rw=1 busy=0",
                     $time, gnt0, gnt1, RegWrite, busy);
        end
    end

    task automatic check_bank(input string name, input int idx, input logic [3:0] want);
        n_tests++;
        if (dbank[idx] !== want) begin
            n_fail++;
            $display("FAIL %s addr=%0d got %0h want %0h", name, idx, dbank[idx], want);
        end
    endtask

    task automatic preload_f();
        for (int i = 0; i < 8; i++) begin
            req0 = 1; addr0 = 3'(i); data0 = 4'hF;
            @(negedge clk);
            req0 = 0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        bit seen;
        rst = 1; req0 = 0; req1 = 0; clr = 0;
        addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        repeat (2) @(negedge clk);
        rst = 0;

        // Single write
        req0 = 1; addr0 = 3; data0 = 9;
        @(negedge clk);
        req0 = 0;
        repeat (3) @(negedge clk);
        check_bank("single_write", 3, 4'h9);

        // Contention from reset
        pulse_rst();
        req0 = 1; addr0 = 1; data0 = 4'hA;
        req1 = 1; addr1 = 6; data1 = 4'h5;
        repeat (6) @(negedge clk);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Held single request, then a tie
        req1 = 1; addr1 = 5; data1 = 4'h7;
        repeat (6) @(negedge clk);
        req1 = 0;
        @(negedge clk);
        req0 = 1; req1 = 1; addr0 = 4; data0 = 4'h2;
        @(negedge clk);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Clear with a second clr mid-sequence
        preload_f();
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (3) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) check_bank("clear_all", i, 4'h0);

        // Clear with a pending request
        clr = 1; req0 = 1; addr0 = 2; data0 = 6;
        @(negedge clk);
        clr = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt0) seen = 1;
        end
        req0 = 0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL clear_pending_grant got no gnt0 within 20 cycles want gnt0");
        end
        repeat (2) @(negedge clk);
        check_bank("clear_pending", 2, 4'h6);

        // Reset part-way through a clear
        preload_f();
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) check_bank("reset_mid_clear", i, (i < 3) ? 4'h0 : 4'hF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (gnt0) begin
                if ($urandom_range(1, 0) == 1) begin
                    addr0 = 3'($urandom); data0 = 4'($urandom);
                end else req0 = 0;
            end else if (!req0 && $urandom_range(2, 0) == 0) begin
                req0 = 1; addr0 = 3'($urandom); data0 = 4'($urandom);
            end
            if (gnt1) begin
                if ($urandom_range(1, 0) == 1) begin
                    addr1 = 3'($urandom); data1 = 4'($urandom);
                end else req1 = 0;
            end else if (!req1 && $urandom_range(2, 0) == 0) begin
                req1 = 1; addr1 = 3'($urandom); data1 = 4'($urandom);
            end
            clr = ($urandom_range(39, 0) == 0);
            rst = ($urandom_range(299, 0) == 0);
            @(negedge clk);
        end
        req0 = 0; req1 = 0; clr = 0; rst = 0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 8; i++) check_bank("bank_vs_model", i, mbank[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
